// File: rtl/debounce_pkg.sv
// Shared types, default parameters and width helper for the multi-channel
// push-button debouncer.
package debounce_pkg;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CLK_DIV      = 1000;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_HOLD_TICKS   = 500;
  localparam int DEF_REPEAT_TICKS = 100;

  // One bit per button channel at the default channel count.
  typedef logic [DEF_NUM_CH-1:0] ch_vec_t;

  // Bits needed for a counter that must represent the values 0..num_vals-1.
  function automatic int cnt_w(input int num_vals);
    if (num_vals <= 2) begin
      return 1;
    end else begin
      return $clog2(num_vals);
    end
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: 2-flop synchroniser, tick-sampled shift
// register, level/strobe generation and, when BTN_DEBOUNCE_REPEAT_EN is
// defined, the auto-repeat hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  logic [1:0]       sync_r;
  logic [DEPTH-1:0] shreg_r;
  logic             level_r;
  logic             press_r;
  logic             release_r;
  logic             rise_s;
  logic             fall_s;

  // A full window of ones (zeros) is the only way the level may flip.
  assign rise_s = (&shreg_r) & ~level_r;
  assign fall_s = ~(|shreg_r) & level_r;

  // Bring the asynchronous button input into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn};
    end
  end

  // Record the synchronised input once per shared sample tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_r <= {DEPTH{1'b0}};
    end else if (tick) begin
      shreg_r <= {shreg_r[DEPTH-2:0], sync_r[1]};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Update the stable level and emit the matching one-cycle edge strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= rise_s;
      release_r <= fall_s;
      if (rise_s) begin
        level_r <= 1'b1;
      end else if (fall_s) begin
        level_r <= 1'b0;
      end else begin
        level_r <= level_r;
      end
    end
  end

  assign o_level   = level_r;
  assign o_press   = press_r;
  assign o_release = release_r;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  // The counter runs up to HOLD+REPEAT and then folds back to HOLD, so each
  // later pass through the top value is exactly REPEAT_TICKS ticks apart.
  localparam int RW = cnt_w(HOLD_TICKS + REPEAT_TICKS + 1);
  localparam logic [RW-1:0] HOLD_V = RW'(HOLD_TICKS);
  localparam logic [RW-1:0] WRAP_V = RW'(HOLD_TICKS + REPEAT_TICKS);

  logic [RW-1:0] rpt_cnt_r;
  logic [RW-1:0] rpt_nxt_s;
  logic          rpt_hit_s;
  logic          repeat_r;

  assign rpt_nxt_s = rpt_cnt_r + RW'(1);
  // A release due in the same cycle suppresses the repeat strobe.
  assign rpt_hit_s = tick & level_r & ~fall_s &
                     ((rpt_nxt_s == HOLD_V) | (rpt_nxt_s == WRAP_V));

  // Count ticks while the button is held and strobe at the repeat points.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_r <= {RW{1'b0}};
      repeat_r  <= 1'b0;
    end else begin
      repeat_r <= rpt_hit_s;
      if (!level_r || fall_s) begin
        rpt_cnt_r <= {RW{1'b0}};
      end else if (tick) begin
        rpt_cnt_r <= (rpt_nxt_s == WRAP_V) ? HOLD_V : rpt_nxt_s;
      end else begin
        rpt_cnt_r <= rpt_cnt_r;
      end
    end
  end

  assign o_repeat = repeat_r;
`else
  // Hold/repeat parameters only matter when auto-repeat is built in.
  logic unused_cfg_s;
  assign unused_cfg_s = (HOLD_TICKS > 0) ^ (REPEAT_TICKS > 0);
  assign o_repeat     = 1'b0;
`endif

endmodule

// File: rtl/multi_btn_debounce.sv
// Multi-channel push-button conditioner: one shared sample-tick generator
// feeding NUM_CH independent debounce channels. Define
// BTN_DEBOUNCE_REPEAT_EN to build the per-channel auto-repeat strobe;
// otherwise o_repeat is tied to 0.
module multi_btn_debounce
  import debounce_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] i_btn,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_repeat
);

  localparam int TW = cnt_w(CLK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;

  // Tick is a decode of the registered counter, so it is glitch-free.
  assign tick_s = (tick_cnt_r == TICK_MAX);

  // Free-running 0..CLK_DIV-1 divider shared by every channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEPTH       (DEPTH),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick_s),
      .btn      (i_btn[g]),
      .o_level  (o_level[g]),
      .o_press  (o_press[g]),
      .o_release(o_release[g]),
      .o_repeat (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_multi_btn_debounce.sv
// Self-checking bench for multi_btn_debounce: a run-length behavioural model
// checked every cycle, plus directed scenarios with hand-computed latencies.
module tb_multi_btn_debounce;

  localparam int NCH    = 2;
  localparam int CDIV   = 4;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 8;
  localparam int REPEAT = 3;
  localparam int FIRST_REP = HOLD * CDIV - 1;
  localparam int REP_GAP   = REPEAT * CDIV;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] i_btn = 2'b00;
  logic [NCH-1:0] o_level, o_press, o_release, o_repeat;

  int checks = 0;
  int errors = 0;

  multi_btn_debounce #(
    .NUM_CH(NCH), .CLK_DIV(CDIV), .DEPTH(DEPTH),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REPEAT)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int             m_ph;
  int             m_edge;
  bit             m_tick;
  bit             m_samp;
  int             m_run   [NCH];
  bit             m_runv  [NCH];
  bit             m_lvl   [NCH];
  bit             m_d1    [NCH];
  bit             m_d2    [NCH];
  int             m_press_at [NCH];
  logic [NCH-1:0] exp_level = '0;
  logic [NCH-1:0] exp_press = '0;
  logic [NCH-1:0] exp_rel   = '0;
  logic [NCH-1:0] exp_rep   = '0;

  // Model: input seen two edges late, sampled on every CDIV-th edge; the
  // level follows once DEPTH equal samples in a row disagree with it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph   = 0;
      m_edge = 0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = DEPTH; m_runv[c] = 1'b0; m_lvl[c] = 1'b0;
        m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_press_at[c] = 0;
      end
      exp_level = '0; exp_press = '0; exp_rel = '0; exp_rep = '0;
    end else begin
      m_edge = m_edge + 1;
      m_tick = (m_ph == CDIV - 1);
      m_ph   = (m_ph + 1) % CDIV;
      for (int c = 0; c < NCH; c++) begin
        exp_press[c] = 1'b0; exp_rel[c] = 1'b0; exp_rep[c] = 1'b0;
        if (m_run[c] >= DEPTH && m_runv[c] != m_lvl[c]) begin
          m_lvl[c] = m_runv[c];
          if (m_lvl[c]) begin
            exp_press[c] = 1'b1;
            m_press_at[c] = m_edge;
          end else begin
            exp_rel[c] = 1'b1;
          end
        end
        if (REP_EN && m_lvl[c] && (m_edge - m_press_at[c]) >= FIRST_REP &&
            ((m_edge - m_press_at[c] - FIRST_REP) % REP_GAP) == 0)
          exp_rep[c] = 1'b1;
        exp_level[c] = m_lvl[c];
        m_samp  = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = i_btn[c];
        if (m_tick) begin
          if (m_samp == m_runv[c]) begin
            if (m_run[c] < DEPTH) m_run[c] = m_run[c] + 1;
          end else begin
            m_runv[c] = m_samp;
            m_run[c]  = 1;
          end
        end
      end
    end
  end

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d t=%0t", name, act, lo, hi, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check_int("cyc_level",   int'(o_level),   int'(exp_level));
    check_int("cyc_press",   int'(o_press),   int'(exp_press));
    check_int("cyc_release", int'(o_release), int'(exp_rel));
    check_int("cyc_repeat",  int'(o_repeat),  int'(exp_rep));
  end

  function automatic bit strobe_of(input int kind, input int ch);
    case (kind)
      K_PRESS: return o_press[ch];
      K_REL:   return o_release[ch];
      default: return o_repeat[ch];
    endcase
  endfunction

  // Count clk cycles until the strobe is seen; n = -1 when the bound expires.
  task automatic wait_strobe(input int kind, input int ch, input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (strobe_of(kind, ch)) return;
    end
    n = -1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n, act, rel_cnt, relevel, rep_cnt;
    bit fallen;
    int rep_at [3];

    // Reset held with both buttons pressed: everything stays 0.
    reset = 1'b0; i_btn = 2'b11;
    repeat (6) @(negedge clk);
    check_int("rst_level",   int'(o_level),   0);
    check_int("rst_press",   int'(o_press),   0);
    check_int("rst_release", int'(o_release), 0);
    check_int("rst_repeat",  int'(o_repeat),  0);
    reset = 1'b1;
    wait_strobe(K_PRESS, 0, 40, n);
    check_int("rst_press_lat", n, 17);
    check_int("rst_press_both", int'(o_press), 3);
    @(negedge clk);
    check_int("rst_press_once", int'(o_press), 0);
    check_int("rst_level_hi", int'(o_level), 3);
    i_btn = 2'b00;
    wait_strobe(K_REL, 0, 40, n);
    check_range("rst_rel_lat", n, 16, 19);
    repeat (4) @(negedge clk);

    // Glitch of two ticks on channel 0 is filtered out.
    act = 0; i_btn[0] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 8) i_btn[0] = 1'b0;
      @(negedge clk);
      if (o_level[0] | o_press[0] | o_release[0]) act++;
    end
    check_int("glitch_quiet", act, 0);

    // Clean 40-clk press then release on channel 0.
    i_btn[0] = 1'b1;
    wait_strobe(K_PRESS, 0, 40, n);
    check_range("press_lat", n, 16, 19);
    @(negedge clk);
    check_int("press_width", int'(o_press[0]), 0);
    check_int("press_level", int'(o_level[0]), 1);
    if (n > 0) repeat (40 - n - 1) @(negedge clk);
    check_int("level_before_fall", int'(o_level[0]), 1);
    i_btn[0] = 1'b0;
    wait_strobe(K_REL, 0, 40, n);
    check_range("release_lat", n, 16, 19);
    @(negedge clk);
    check_int("release_width", int'(o_release[0]), 0);
    check_int("release_level", int'(o_level[0]), 0);
    repeat (4) @(negedge clk);

    // Bouncy release on channel 1.
    i_btn[1] = 1'b1;
    wait_strobe(K_PRESS, 1, 40, n);
    check_range("bounce_press_lat", n, 16, 19);
    repeat (4) @(negedge clk);
    rel_cnt = 0; relevel = 0; fallen = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (i < 30) begin
        if (i % 3 == 0) i_btn[1] = ~i_btn[1];
      end else begin
        i_btn[1] = 1'b0;
      end
      @(negedge clk);
      if (o_release[1]) begin
        rel_cnt++;
        fallen = 1'b1;
      end else if (fallen && o_level[1]) begin
        relevel++;
      end
    end
    check_range("bounce_rel_count", rel_cnt, 0, 1);
    check_int("bounce_no_relevel", relevel, 0);
    check_int("bounce_final_level", int'(o_level[1]), 0);

    // Reset 10 clk into a press discards the progress.
    i_btn[0] = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0; act = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (|{o_level, o_press, o_release, o_repeat}) act++;
    end
    check_int("mid_rst_quiet", act, 0);
    reset = 1'b1;
    wait_strobe(K_PRESS, 0, 40, n);
    check_int("mid_rst_press_lat", n, 17);

    // Hold channel 0 and collect repeat strobes relative to the press.
    rep_cnt = 0;
    for (int i = 0; i < 3; i++) rep_at[i] = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (o_repeat[0]) begin
        if (rep_cnt < 3) rep_at[rep_cnt] = i;
        rep_cnt++;
      end
    end
`ifdef BTN_DEBOUNCE_REPEAT_EN
    check_int("repeat_first",  rep_at[0], 31);
    check_int("repeat_second", rep_at[1], 43);
    check_int("repeat_third",  rep_at[2], 55);
`else
    check_int("repeat_absent", rep_cnt, 0);
`endif
    i_btn[0] = 1'b0;
    wait_strobe(K_REL, 0, 40, n);
    check_range("hold_rel_lat", n, 16, 19);
    act = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_repeat[0]) act++;
    end
    check_int("repeat_stops", act, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
